dmem_banked_ctrl: RTL and testbench

//  Handshaked, 4-lane byte-banked data memory for the MEM stage; replaces the purely combinational bank-select memory.

---
 rtl/dmem_banked_ctrl_if.sv | 32 +++
 rtl/dmem_banked_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_dmem_banked_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_banked_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module      : dmem_banked_ctrl_if                                          |
// | Description : Request/response bus of the banked MEM-stage data memory.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface dmem_banked_ctrl_if #(
    parameter int AW = 15
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_type;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/dmem_banked_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : dmem_banked_ctrl                                             |
// | Description : Handshaked 4-lane byte-banked data memory, sync-read banks,  |
// |               RV32 B/H/W loads and stores, word boot-load port in debug.   |
// |               Define DMEM_MISALIGN_SPLIT_EN to split misaligned H/W        |
// |               accesses into two bank beats; otherwise they trap.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_banked_ctrl #(
    parameter int    DEPTH_WORDS = 8192,
    parameter string INIT_FILE   = ""
) (
    input  wire logic                           clk,
    input  wire logic                           rst_n,
    dmem_banked_ctrl_if.slave                   bus,
    input  wire logic                           debug,
    input  wire logic                           boot_we,
    input  wire logic [$clog2(DEPTH_WORDS)-1:0] boot_addr,
    input  wire logic [31:0]                    boot_data
);

    localparam int AW = $clog2(DEPTH_WORDS) + 2;
    localparam int WA = AW - 2;

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit c_split_en = 1'b1;
`else
    localparam bit c_split_en = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT1 = 2'd1,
        S_BEAT2 = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Access decode helpers
    // ------------------------------------------------------------------
    function automatic logic [2:0] f_size(input logic [2:0] t);
        case (t[1:0])
            2'b00:   f_size = 3'd1;
            2'b01:   f_size = 3'd2;
            default: f_size = 3'd4;
        endcase
    endfunction

    function automatic logic f_legal(input logic [2:0] t, input logic we);
        case (t)
            3'b000, 3'b001, 3'b010: f_legal = 1'b1;
            3'b100, 3'b101:         f_legal = ~we;
            default:                f_legal = 1'b0;
        endcase
    endfunction

    function automatic logic f_misal(input logic [2:0] t, input logic [1:0] a);
        f_misal = ((t[1:0] == 2'b01) && (a == 2'b11)) ||
                  ((t[1:0] == 2'b10) && (a != 2'b00));
    endfunction

    // Lanes touched by a beat: byte positions a..a+n-1 of the two-word window
    function automatic logic [3:0] f_lanes(input logic [1:0] a, input logic [2:0] n,
                                           input logic beat);
        logic [3:0] lo;
        logic [3:0] hi;
        logic [3:0] pos;
        lo = {2'b00, a};
        hi = lo + {1'b0, n};
        for (int l = 0; l < 4; l++) begin
            pos        = 4'(l) + (beat ? 4'd4 : 4'd0);
            f_lanes[l] = (pos >= lo) && (pos < hi);
        end
    endfunction

    function automatic logic [3:0][7:0] f_rotate(input logic [31:0] d, input logic [1:0] a);
        logic [1:0] i;
        for (int l = 0; l < 4; l++) begin
            i           = 2'(l) - a;
            f_rotate[l] = d[{i, 3'b000} +: 8];
        end
    endfunction

    function automatic logic [31:0] f_extend(input logic [2:0] t, input logic [31:0] v);
        case (t)
            3'b000:  f_extend = {{24{v[7]}}, v[7:0]};
            3'b001:  f_extend = {{16{v[15]}}, v[15:0]};
            3'b100:  f_extend = {24'h0, v[7:0]};
            3'b101:  f_extend = {16'h0, v[15:0]};
            default: f_extend = v;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          r_state;
    logic            r_live;
    logic            r_we;
    logic [2:0]      r_type;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic            r_err;
    logic            r_split;
    logic [3:0][7:0] r_hold;
    logic            r_rsp_valid;
    logic [31:0]     r_rsp_rdata;
    logic            r_rsp_err;

    // ------------------------------------------------------------------
    // Request decode and bank port arbitration
    // ------------------------------------------------------------------
    logic            w_req_ready;
    logic            w_accept;
    logic            w_in_ok;
    logic            w_in_misal;
    logic            w_boot;
    logic            w_beat1;
    logic [3:0]      w_en;
    logic            w_wr;
    logic [WA-1:0]   w_word;
    logic [3:0][7:0] w_wbyte;
    logic [3:0][7:0] w_lane_q;
    logic [3:0][7:0] w_merged;
    logic [31:0]     w_gather;
    logic [31:0]     w_load;

    // r_live keeps req_ready low while reset is asserted
    assign w_req_ready = r_live & (r_state == S_IDLE) & ~debug;
    assign w_accept    = bus.req_valid & w_req_ready;
    assign w_in_misal  = f_misal(bus.req_type, bus.req_addr[1:0]);
    assign w_in_ok     = f_legal(bus.req_type, bus.req_we) & (~w_in_misal | c_split_en);
    assign w_boot      = debug & boot_we;
    assign w_beat1     = (r_state == S_BEAT1) & r_split;

    always_comb begin
        w_en    = 4'h0;
        w_wr    = 1'b0;
        w_word  = '0;
        w_wbyte = '0;
        // Boot writes own the bank port; a colliding second beat retries.
        if (w_boot) begin
            w_en    = 4'hF;
            w_wr    = 1'b1;
            w_word  = boot_addr;
            w_wbyte = boot_data;
        end else if (w_accept && w_in_ok) begin
            w_en    = f_lanes(bus.req_addr[1:0], f_size(bus.req_type), 1'b0);
            w_wr    = bus.req_we;
            w_word  = bus.req_addr[AW-1:2];
            w_wbyte = f_rotate(bus.req_wdata, bus.req_addr[1:0]);
        end else if (w_beat1) begin
            w_en    = f_lanes(r_addr[1:0], f_size(r_type), 1'b1);
            w_wr    = r_we;
            w_word  = r_addr[AW-1:2] + WA'(1);
            w_wbyte = f_rotate(r_wdata, r_addr[1:0]);
        end
    end

    // ------------------------------------------------------------------
    // Byte lanes: one sync-read/write port each, contents never reset
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (w_en[k]) begin
                if (w_wr) begin
                    r_mem[w_word] <= w_wbyte[k];
                end else begin
                    r_q <= r_mem[w_word];
                end
            end
        end

        assign w_lane_q[k] = r_q;
    end

    // ------------------------------------------------------------------
    // Load assembly: in BEAT2 the upper lanes come from the held first beat
    // ------------------------------------------------------------------
    always_comb begin
        w_merged = w_lane_q;
        w_gather = '0;
        if (r_state == S_BEAT2) begin
            for (int l = 0; l < 4; l++) begin
                if (2'(l) >= r_addr[1:0]) begin
                    w_merged[l] = r_hold[l];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            w_gather[8*i +: 8] = w_merged[2'(i) + r_addr[1:0]];
        end
    end

    assign w_load = f_extend(r_type, w_gather);

    // ------------------------------------------------------------------
    // Control FSM with registered response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_live      <= 1'b0;
            r_we        <= 1'b0;
            r_type      <= 3'b000;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_split     <= 1'b0;
            r_hold      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_live      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= bus.req_we;
                        r_type  <= bus.req_type;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_err   <= ~w_in_ok;
                        r_split <= w_in_ok & w_in_misal;
                        r_state <= S_BEAT1;
                    end
                end
                S_BEAT1: begin
                    if (r_split) begin
                        if (!w_boot) begin
                            r_hold  <= w_lane_q;
                            r_state <= S_BEAT2;
                        end
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= r_err;
                        r_rsp_rdata <= (r_err || r_we) ? 32'h0 : w_load;
                        r_state     <= S_IDLE;
                    end
                end
                S_BEAT2: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= r_we ? 32'h0 : w_load;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_banked_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_dmem_banked_ctrl                                          |
// | Description : Directed table, boot/reset sequences and random traffic      |
// |               against a flat byte-array model of dmem_banked_ctrl.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dmem_banked_ctrl;

    localparam int DEPTH = 8192;
    localparam int AW    = 15;
    localparam int MEMB  = DEPTH * 4;

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          debug     = 1'b0;
    logic          boot_we   = 1'b0;
    logic [AW-3:0] boot_addr = '0;
    logic [31:0]   boot_data = '0;

    always #5 clk = ~clk;

    dmem_banked_ctrl_if #(.AW(AW)) bus ();

    dmem_banked_ctrl #(.DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .debug     (debug),
        .boot_we   (boot_we),
        .boot_addr (boot_addr),
        .boot_data (boot_data)
    );

    int n_vec  = 0;
    int n_miss = 0;
    logic [7:0] mm [MEMB];

    typedef struct {
        string         nm;
        logic          we;
        logic [2:0]    typ;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic [31:0]   rd;
        logic          er;
        int            lat;
    } vec_t;

    vec_t tbl[$];

    function automatic void addv(input string nm, input logic we, input logic [2:0] typ,
                                 input int addr, input logic [31:0] wd, input logic [31:0] rd,
                                 input logic er, input int lat);
        vec_t v;
        v.nm = nm; v.we = we; v.typ = typ; v.addr = AW'(addr);
        v.wd = wd; v.rd = rd; v.er = er; v.lat = lat;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Flat byte memory: an access is n consecutive bytes with address wrap.
    function automatic void model(input logic we, input logic [2:0] typ, input int addr,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output logic er, output int lat);
        int n;
        logic [31:0] v;
        bit legal;
        bit mis;
        n     = (typ[1:0] == 2'd0) ? 1 : (typ[1:0] == 2'd1) ? 2 : 4;
        legal = (typ == 3'd0) || (typ == 3'd1) || (typ == 3'd2) ||
                (((typ == 3'd4) || (typ == 3'd5)) && !we);
        mis   = legal && ((addr % 4) + n > 4);
        rd = '0; er = 1'b0; lat = 1; v = '0;
        if (!legal || (mis && !SPLIT)) begin
            er = 1'b1;
        end else begin
            if (mis) lat = 2;
            for (int i = 0; i < n; i++) begin
                if (we) mm[(addr + i) % MEMB] = wd[8*i +: 8];
                else    v[8*i +: 8] = mm[(addr + i) % MEMB];
            end
            if (!we) begin
                case (typ)
                    3'd0:    rd = {{24{v[7]}}, v[7:0]};
                    3'd1:    rd = {{16{v[15]}}, v[15:0]};
                    3'd4:    rd = {24'h0, v[7:0]};
                    3'd5:    rd = {16'h0, v[15:0]};
                    default: rd = v;
                endcase
            end
        end
    endfunction

    task automatic do_req(input logic we, input logic [2:0] typ, input logic [AW-1:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        int guard;
        rd = '0; er = 1'b0; lat = -1;
        @(negedge clk);
        bus.req_we = we; bus.req_type = typ; bus.req_addr = addr; bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            n_vec++;
            n_miss++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end else begin
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            lat = 0;
            do begin
                @(posedge clk);
                #1 lat++;
                if (!bus.rsp_valid)
                    chk("rsp_idle_zero", bus.rsp_rdata | {31'h0, bus.rsp_err}, 32'h0);
            end while (!bus.rsp_valid && lat < 8);
            if (bus.rsp_valid) begin
                rd = bus.rsp_rdata;
                er = bus.rsp_err;
            end else begin
                lat = -1;
            end
        end
    endtask

    task automatic run_chk(input string nm, input logic we, input logic [2:0] typ,
                           input int addr, input logic [31:0] wd);
        logic [31:0] erd, ard;
        logic        eer, aer;
        int          elat, alat;
        model(we, typ, addr, wd, erd, eer, elat);
        do_req(we, typ, AW'(addr), wd, ard, aer, alat);
        chk({nm, " rdata"}, ard, erd);
        chk({nm, " err"}, {31'h0, aer}, {31'h0, eer});
        chk({nm, " lat"}, 32'(alat), 32'(elat));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        seen;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_type = '0;
        bus.req_addr  = '0;   bus.req_wdata = '0;

        addv("sw_dead",   1, 3'd2, 'h10,   32'hDEADBEEF, 32'h0,        0, 1);
        addv("lw_dead",   0, 3'd2, 'h10,   32'h0,        32'hDEADBEEF, 0, 1);
        addv("sb_80",     1, 3'd0, 'h13,   32'h80,       32'h0,        0, 1);
        addv("lb_13",     0, 3'd0, 'h13,   32'h0,        32'hFFFFFF80, 0, 1);
        addv("lbu_13",    0, 3'd4, 'h13,   32'h0,        32'h00000080, 0, 1);
        addv("lw_10",     0, 3'd2, 'h10,   32'h0,        32'h80ADBEEF, 0, 1);
        addv("lh_12",     0, 3'd1, 'h12,   32'h0,        32'hFFFF80AD, 0, 1);
        addv("lhu_11",    0, 3'd5, 'h11,   32'h0,        32'h0000ADBE, 0, 1);
        addv("sw_20",     1, 3'd2, 'h20,   32'hCAFEF00D, 32'h0,        0, 1);
        addv("sw_24",     1, 3'd2, 'h24,   32'h0,        32'h0,        0, 1);
        addv("sw_mis21",  1, 3'd2, 'h21,   32'h11223344, 32'h0,        !SPLIT, SPLIT ? 2 : 1);
        addv("lw_20",     0, 3'd2, 'h20,   32'h0, SPLIT ? 32'h2233440D : 32'hCAFEF00D, 0, 1);
        addv("lbu_24",    0, 3'd4, 'h24,   32'h0, SPLIT ? 32'h11 : 32'h0, 0, 1);
        addv("lw_mis22",  0, 3'd2, 'h22,   32'h0, SPLIT ? 32'h00112233 : 32'h0, !SPLIT, SPLIT ? 2 : 1);
        addv("sb_0",      1, 3'd0, 'h0,    32'h0,        32'h0,        0, 1);
        addv("sh_wrap",   1, 3'd1, 'h7FFF, 32'hA5A5,     32'h0,        !SPLIT, SPLIT ? 2 : 1);
        addv("lhu_wrap",  0, 3'd5, 'h7FFF, 32'h0, SPLIT ? 32'h0000A5A5 : 32'h0, !SPLIT, SPLIT ? 2 : 1);
        addv("lh_wrap",   0, 3'd1, 'h7FFF, 32'h0, SPLIT ? 32'hFFFFA5A5 : 32'h0, !SPLIT, SPLIT ? 2 : 1);
        addv("lbu_0",     0, 3'd4, 'h0,    32'h0, SPLIT ? 32'hA5 : 32'h0, 0, 1);
        addv("ld_011",    0, 3'd3, 'h10,   32'h0,        32'h0,        1, 1);
        addv("st_bu",     1, 3'd4, 'h10,   32'hFF,       32'h0,        1, 1);
        addv("st_hu",     1, 3'd5, 'h12,   32'hFFFF,     32'h0,        1, 1);
        addv("ld_111",    0, 3'd7, 'h10,   32'h0,        32'h0,        1, 1);
        addv("lw_10_keep",0, 3'd2, 'h10,   32'h0,        32'h80ADBEEF, 0, 1);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst req_ready", {31'h0, bus.req_ready}, 32'h0);
        chk("rst rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst rsp_err",   {31'h0, bus.rsp_err}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready after rst", {31'h0, bus.req_ready}, 32'h1);

        foreach (tbl[j]) begin
            do_req(tbl[j].we, tbl[j].typ, tbl[j].addr, tbl[j].wd, rd, er, lat);
            chk({tbl[j].nm, " rdata"}, rd, tbl[j].rd);
            chk({tbl[j].nm, " err"}, {31'h0, er}, {31'h0, tbl[j].er});
            chk({tbl[j].nm, " lat"}, 32'(lat), 32'(tbl[j].lat));
        end

        // Boot write while a request waits: request must stay blocked
        @(negedge clk);
        debug = 1'b1; boot_we = 1'b1; boot_addr = 'd5; boot_data = 32'h01020304;
        bus.req_we = 1'b0; bus.req_type = 3'd2; bus.req_addr = 'h14; bus.req_valid = 1'b1;
        #1 chk("debug req_ready", {31'h0, bus.req_ready}, 32'h0);
        @(posedge clk);
        #1 chk("debug no accept", {31'h0, bus.rsp_valid | bus.req_ready}, 32'h0);
        @(negedge clk);
        debug = 1'b0; boot_we = 1'b0; bus.req_valid = 1'b0;
        do_req(1'b0, 3'd2, 'h14, 32'h0, rd, er, lat);
        chk("boot lw14 rdata", rd, 32'h01020304);
        chk("boot lw14 lat", 32'(lat), 32'd1);

        // Boot write collides with the second beat of a split store
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_type = 3'd2; bus.req_addr = 'h31;
        bus.req_wdata = 32'h55667788; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        debug = 1'b1; boot_we = 1'b1; boot_addr = 'd13; boot_data = 32'hAABBCCDD;
        lat = 0;
        do begin
            @(posedge clk);
            #1 boot_we = 1'b0;
            lat++;
        end while (!bus.rsp_valid && lat < 8);
        chk("collide lat", 32'(lat), SPLIT ? 32'd3 : 32'd1);
        chk("collide err", {31'h0, bus.rsp_err}, {31'h0, !SPLIT});
        @(negedge clk);
        debug = 1'b0;
        do_req(1'b0, 3'd2, 'h34, 32'h0, rd, er, lat);
        chk("collide lw34", rd, SPLIT ? 32'hAABBCC55 : 32'hAABBCCDD);

        // Random traffic on the low 16 and top 16 words (wrap region)
        for (int w = 0; w < 16; w++) begin
            run_chk("init lo", 1'b1, 3'd2, w * 4, $urandom);
            run_chk("init hi", 1'b1, 3'd2, MEMB - 64 + w * 4, $urandom);
        end
        for (int r = 0; r < 250; r++) begin
            int k;
            k = $urandom_range(0, 127);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            run_chk("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    (k < 64) ? k : MEMB - 128 + k, $urandom);
        end

        // Reset while the first beat of a split store is in flight
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_type = 3'd2; bus.req_addr = 'h21;
        bus.req_wdata = 32'h99AABBCC; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk("midrst req_ready", {31'h0, bus.req_ready}, 32'h0);
        chk("midrst rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1 seen = seen | bus.rsp_valid;
        end
        chk("midrst no rsp", {31'h0, seen}, 32'h0);
        if (SPLIT) begin
            mm['h21] = 8'hCC; mm['h22] = 8'hBB; mm['h23] = 8'hAA;
        end
        run_chk("midrst lw20", 1'b0, 3'd2, 'h20, 32'h0);
        run_chk("midrst lw24", 1'b0, 3'd2, 'h24, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
